// File: rtl/apb_bus1_ctrl.sv
`timescale 1ns/1ps
// apb_bus1_ctrl: single-master APB controller for Bus[1], six-slot fixed address map.
// Optional ACCESS-phase timeout is compiled in with `define BUS1_APB_TIMEOUT_EN.
module apb_bus1_ctrl #(
    parameter int TIMEOUT = 1024
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [63:0]  i_req_addr,
    input  logic         i_req_write,
    input  logic [31:0]  i_req_wdata,
    input  logic [3:0]   i_req_wstrb,
    output logic         o_resp_valid,
    input  logic         i_resp_ready,
    output logic [31:0]  o_resp_rdata,
    output logic         o_resp_err,
    // slot i: o_apbo[74*i +: 74] = {paddr[31:0], pprot[2:0], psel, penable, pwrite, pwdata[31:0], pstrb[3:0]}
    output logic [443:0] o_apbo,
    // slot i: i_apbi[34*i +: 34] = {pready, prdata[31:0], pslverr}
    input  logic [203:0] i_apbi
);

    localparam int SLV_TOTAL = 6;
    localparam int APBO_W    = 74;
    localparam int APBI_W    = 34;

    // uart1, PRCI, DMI, GPIO, DDR MGMT, PnP; end addresses are exclusive
    localparam logic [63:0] SLV_BASE [SLV_TOTAL] = '{
        64'h0001_0000, 64'h0001_2000, 64'h0001_E000,
        64'h0006_0000, 64'h000C_0000, 64'h000F_F000};
    localparam logic [63:0] SLV_END  [SLV_TOTAL] = '{
        64'h0001_1000, 64'h0001_3000, 64'h0001_F000,
        64'h0006_1000, 64'h000C_1000, 64'h0010_0000};

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  sel_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_nxt;
    logic        err_q;
    logic        err_nxt;
    logic        load_resp;
    logic        dec_hit;
    logic [2:0]  dec_idx;
    logic        pready_sel;
    logic        pslverr_sel;
    logic [31:0] prdata_sel;
    logic        expired;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("apb_bus1_ctrl: TIMEOUT must be at least 2");
    end

    // descending scan so the lowest matching slot is the one left standing
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = SLV_TOTAL - 1; i >= 0; i--) begin
            if (i_req_addr >= SLV_BASE[i] && i_req_addr < SLV_END[i]) begin
                dec_hit = 1'b1;
                dec_idx = 3'(i);
            end
        end
    end

    always_comb begin
        pready_sel  = 1'b0;
        prdata_sel  = '0;
        pslverr_sel = 1'b0;
        for (int i = 0; i < SLV_TOTAL; i++) begin
            if (sel_q == 3'(i)) begin
                pready_sel  = i_apbi[APBI_W*i + 33];
                prdata_sel  = i_apbi[APBI_W*i + 1 +: 32];
                pslverr_sel = i_apbi[APBI_W*i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_req_valid) begin
            addr_q  <= i_req_addr[31:0];
            write_q <= i_req_write;
            wdata_q <= i_req_wdata;
            wstrb_q <= i_req_wstrb;
            sel_q   <= dec_idx;
        end
    end

`ifdef BUS1_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cnt_q <= '0;
        end else if (state == SETUP) begin
            cnt_q <= '0;
        end else if (state == ACCESS && !pready_sel) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_resp) begin
                rdata_q <= rdata_nxt;
                err_q   <= err_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load_resp = 1'b0;
        rdata_nxt = '0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    if (dec_hit) begin
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = RESP;
                        load_resp = 1'b1;
                        err_nxt   = 1'b1;
                    end
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                // pready in the expiry cycle still completes normally
                if (pready_sel) begin
                    state_nxt = RESP;
                    load_resp = 1'b1;
                    rdata_nxt = (write_q || pslverr_sel) ? 32'h0 : prdata_sel;
                    err_nxt   = pslverr_sel;
                end else if (expired) begin
                    state_nxt = RESP;
                    load_resp = 1'b1;
                    err_nxt   = 1'b1;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_apbo = '0;
        if (state == SETUP || state == ACCESS) begin
            for (int i = 0; i < SLV_TOTAL; i++) begin
                if (sel_q == 3'(i)) begin
                    o_apbo[APBO_W*i +: APBO_W] = {addr_q, 3'b000, 1'b1, state == ACCESS, write_q,
                                                  write_q ? wdata_q : 32'h0,
                                                  write_q ? wstrb_q : 4'h0};
                end
            end
        end
    end

    assign o_req_ready  = (state == IDLE);
    assign o_resp_valid = (state == RESP);
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;

endmodule

// File: tb/tb_apb_bus1_ctrl.sv
`timescale 1ns/1ps
// Randomized self-checking bench for apb_bus1_ctrl with a transaction-level reference model.
module tb_apb_bus1_ctrl;

    localparam int TB_TIMEOUT = 8;
`ifdef BUS1_APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         i_clk = 1'b0;
    logic         i_nrst;
    logic         i_req_valid;
    logic         o_req_ready;
    logic [63:0]  i_req_addr;
    logic         i_req_write;
    logic [31:0]  i_req_wdata;
    logic [3:0]   i_req_wstrb;
    logic         o_resp_valid;
    logic         i_resp_ready;
    logic [31:0]  o_resp_rdata;
    logic         o_resp_err;
    logic [443:0] o_apbo;
    logic [203:0] i_apbi;

    logic         pready_s  [6];
    logic [31:0]  prdata_s  [6];
    logic         pslverr_s [6];

    int total = 0;
    int bad   = 0;

    logic [63:0] map_base [6] = '{64'h10000, 64'h12000, 64'h1E000, 64'h60000, 64'hC0000, 64'hFF000};
    logic [63:0] map_end  [6] = '{64'h11000, 64'h13000, 64'h1F000, 64'h61000, 64'hC1000, 64'h100000};

    apb_bus1_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_write(i_req_write),
        .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
        .o_apbo(o_apbo), .i_apbi(i_apbi)
    );

    always #5 i_clk = ~i_clk;

    always_comb begin
        i_apbi = '0;
        for (int i = 0; i < 6; i++) begin
            i_apbi[34*i +: 34] = {pready_s[i], prdata_s[i], pslverr_s[i]};
        end
    end

    task automatic check_eq(input string tag, input logic [447:0] got, input logic [447:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_slot(input logic [63:0] a);
        for (int i = 0; i < 6; i++) begin
            if (a >= map_base[i] && a < map_end[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [443:0] exp_apbo(input int slot, input logic [63:0] a, input bit wr,
                                              input logic [31:0] wd, input logic [3:0] ws, input bit en);
        logic [443:0] v;
        logic [73:0]  f;
        v = '0;
        f = {a[31:0], 3'b000, 1'b1, en, wr, wr ? wd : 32'h0, wr ? ws : 4'h0};
        v[slot*74 +: 74] = f;
        return v;
    endfunction

    // Starts and ends at a falling edge; waits = pready-low cycles in ACCESS, bp = resp_ready-low cycles
    task automatic run_txn(input logic [63:0] a, input bit wr, input logic [31:0] wd, input logic [3:0] ws,
                           input int waits, input bit slverr, input logic [31:0] rd, input int bp,
                           input string tag);
        int          slot;
        bit          timed_out;
        int          ncyc;
        logic [31:0] exp_rd;
        bit          exp_err;
        slot = ref_slot(a);
        for (int i = 0; i < 6; i++) begin
            if (i == slot) begin
                pready_s[i] = 1'b0; pslverr_s[i] = 1'b0; prdata_s[i] = 32'h0;
            end else begin
                pready_s[i] = 1'($urandom); pslverr_s[i] = 1'($urandom); prdata_s[i] = $urandom;
            end
        end
        i_req_valid = 1'b1; i_req_addr = a; i_req_write = wr; i_req_wdata = wd; i_req_wstrb = ws;
        i_resp_ready = 1'b0;
        check_eq($sformatf("%s.req_ready", tag), o_req_ready, 1);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_req_addr = {$urandom, $urandom}; i_req_wdata = $urandom; i_req_wstrb = 4'($urandom);
        i_req_write = 1'($urandom);
        if (slot < 0) begin
            exp_err = 1'b1;
            exp_rd  = 32'h0;
        end else begin
            timed_out = TO_EN && (waits >= TB_TIMEOUT);
            ncyc = timed_out ? TB_TIMEOUT : waits + 1;
            check_eq($sformatf("%s.setup_apbo", tag), o_apbo, exp_apbo(slot, a, wr, wd, ws, 1'b0));
            check_eq($sformatf("%s.setup_busy", tag), {o_req_ready, o_resp_valid}, 2'b00);
            @(negedge i_clk);
            for (int w = 0; w < ncyc; w++) begin
                check_eq($sformatf("%s.access%0d_apbo", tag, w), o_apbo, exp_apbo(slot, a, wr, wd, ws, 1'b1));
                pready_s[slot]  = !timed_out && (w == waits);
                prdata_s[slot]  = rd;
                pslverr_s[slot] = slverr;
                @(negedge i_clk);
            end
            pready_s[slot] = 1'b0;
            exp_err = timed_out ? 1'b1 : slverr;
            exp_rd  = (timed_out || wr || slverr) ? 32'h0 : rd;
        end
        for (int b = 0; b <= bp; b++) begin
            check_eq($sformatf("%s.resp%0d_valid", tag, b), o_resp_valid, 1);
            check_eq($sformatf("%s.resp%0d_rdata", tag, b), o_resp_rdata, exp_rd);
            check_eq($sformatf("%s.resp%0d_err", tag, b), o_resp_err, exp_err);
            check_eq($sformatf("%s.resp%0d_busy", tag, b), o_req_ready, 0);
            check_eq($sformatf("%s.resp%0d_apbo", tag, b), o_apbo, 444'h0);
            i_resp_ready = (b == bp);
            @(negedge i_clk);
        end
        i_resp_ready = 1'b0;
        check_eq($sformatf("%s.done", tag), {o_resp_valid, o_req_ready}, 2'b01);
    endtask

    initial begin
        logic [63:0] a;
        int          pick;
        i_nrst = 1'b0; i_req_valid = 1'b0; i_req_addr = '0; i_req_write = 1'b0;
        i_req_wdata = '0; i_req_wstrb = '0; i_resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pready_s[i] = 1'b0; prdata_s[i] = '0; pslverr_s[i] = 1'b0;
        end
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("rst.req_ready", o_req_ready, 1);
        check_eq("rst.resp_valid", o_resp_valid, 0);
        check_eq("rst.resp_rdata", o_resp_rdata, 0);
        check_eq("rst.resp_err", o_resp_err, 0);
        check_eq("rst.apbo", o_apbo, 444'h0);
        i_nrst = 1'b1;
        @(negedge i_clk);

        run_txn(64'h12004, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hA5A5_0001, 0, "prci_rd");
        run_txn(64'h60010, 1'b1, 32'h55, 4'h1, 3, 1'b0, 32'hDEAD_BEEF, 0, "gpio_wr");
        run_txn(64'h20000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, "unmapped");
        run_txn(64'h10008, 1'b0, 32'h0, 4'h0, 0, 1'b1, 32'h1234_5678, 5, "uart_err");
        run_txn(64'h12FFC, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D, 0, "prci_last");
        run_txn(64'h13000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, "prci_end");
        run_txn(64'hFFFFC, 1'b1, 32'hCAFE_0000, 4'hC, 0, 1'b0, 32'h0, 1, "pnp_top");
        run_txn(64'h100000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, "pnp_end");
        run_txn(64'h1_0001_2004, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, "hi_addr");
`ifdef BUS1_APB_TIMEOUT_EN
        run_txn(64'hC0000, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h1111_2222, 0, "ddr_timeout");
        run_txn(64'hC0004, 1'b0, 32'h0, 4'h0, TB_TIMEOUT - 1, 1'b0, 32'h3333_4444, 0, "ddr_edge");
`endif

        // reset in the middle of an ACCESS phase on PnP
        for (int i = 0; i < 6; i++) pready_s[i] = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 64'hFF010; i_req_write = 1'b0;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        check_eq("mid.access_apbo", o_apbo, exp_apbo(5, 64'hFF010, 1'b0, 32'h0, 4'h0, 1'b1));
        i_nrst = 1'b0;
        #1;
        check_eq("mid.rst_apbo", o_apbo, 444'h0);
        check_eq("mid.rst_resp_valid", o_resp_valid, 0);
        check_eq("mid.rst_req_ready", o_req_ready, 1);
        @(negedge i_clk);
        i_nrst = 1'b1;
        run_txn(64'hFF010, 1'b0, 32'h0, 4'h0, 2, 1'b0, 32'h7777_8888, 0, "after_rst");

        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 6);
            if (pick == 6) a = 64'h20000 + 64'($urandom_range(0, 32'h3FFFF));
            else a = map_base[pick] + 64'($urandom_range(0, 32'hFFF) & 32'hFFC);
            run_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3),
                    $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
